// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / periodic terminal-count pulse and a saturating expiry counter.
// Optional freeze input enabled by defining COUNTDOWN_PAUSE_EN.
module countdown_timer #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             abort,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             ready,
    output logic [EXP_W-1:0] exp_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             frozen;
    logic             mode;
    logic [WIDTH-1:0] reload_val;

`ifdef COUNTDOWN_PAUSE_EN
    assign frozen = pause && (state == RUN);
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign frozen       = 1'b0;
`endif

    // Abort outranks a restart, which outranks the terminal-count action.
    always_comb begin
        state_nxt = state;
        busy      = (state == RUN);
        ready     = (state == RUN) && (count == '0) && !frozen;
        if (abort) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = RUN;
        end else if (ready && !mode) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            reload_val <= '0;
            mode       <= 1'b0;
            exp_cnt    <= '0;
        end else if (abort) begin
            count <= '0;
        end else if (start) begin
            count      <= load_val;
            reload_val <= load_val;
            mode       <= auto_reload;
            exp_cnt    <= '0;
        end else if (ready) begin
            if (exp_cnt != '1) begin
                exp_cnt <= exp_cnt + EXP_W'(1);
            end
            // One-shot expiry leaves count parked at zero.
            if (mode) begin
                count <= reload_val;
            end
        end else if ((state == RUN) && !frozen) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random traffic against a behavioural model.
// Pause scenarios are exercised when COUNTDOWN_PAUSE_EN is defined.
module tb_countdown_timer;

`ifdef COUNTDOWN_PAUSE_EN
    localparam bit pause_en = 1'b1;
`else
    localparam bit pause_en = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] load_val;
    logic       auto_reload;
    logic       abort;
    logic       pause;
    logic [7:0] count;
    logic       busy;
    logic       ready;
    logic [3:0] exp_cnt;

    int checks = 0;
    int errors = 0;

    // Model: "armed" timer with cycles left until expiry, period, periodic flag and expiry tally.
    bit m_run;
    bit m_periodic;
    int m_left;
    int m_period;
    int m_expiries;

    countdown_timer #(.WIDTH(8), .EXP_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_val   (load_val),
        .auto_reload(auto_reload),
        .abort      (abort),
        .pause      (pause),
        .count      (count),
        .busy       (busy),
        .ready      (ready),
        .exp_cnt    (exp_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit modelReady(bit p);
        return m_run && (m_left == 0) && !(pause_en && p);
    endfunction

    task automatic modelReset();
        m_run      = 1'b0;
        m_periodic = 1'b0;
        m_left     = 0;
        m_period   = 0;
        m_expiries = 0;
    endtask

    task automatic check1(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(string tag, bit p);
        check1({tag, ".count"}, {24'd0, count}, m_left);
        check1({tag, ".busy"}, {31'd0, busy}, {31'd0, m_run});
        check1({tag, ".ready"}, {31'd0, ready}, {31'd0, modelReady(p)});
        check1({tag, ".exp_cnt"}, {28'd0, exp_cnt}, m_expiries);
    endtask

    // Drive one cycle of inputs from a negedge, check, clock it, advance the model.
    task automatic applyStimulus(bit s, bit [7:0] l, bit a, bit ab, bit p, string tag);
        bit fire;
        start       = s;
        load_val    = l;
        auto_reload = a;
        abort       = ab;
        pause       = p;
        #1;
        checkOutput(tag, p);
        fire = modelReady(p);
        @(posedge clk);
        if (ab) begin
            m_run  = 1'b0;
            m_left = 0;
        end else if (s) begin
            m_run      = 1'b1;
            m_left     = l;
            m_period   = l;
            m_periodic = a;
            m_expiries = 0;
        end else if (fire) begin
            m_expiries = (m_expiries < 15) ? m_expiries + 1 : 15;
            if (m_periodic) m_left = m_period;
            else m_run = 1'b0;
        end else if (m_run && !(pause_en && p)) begin
            m_left = m_left - 1;
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
    endtask

    initial begin
        int pulses;
        rst_n       = 1'b0;
        start       = 1'b0;
        load_val    = 8'd0;
        auto_reload = 1'b0;
        abort       = 1'b0;
        pause       = 1'b0;
        modelReset();
        #2;
        checkOutput("reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot from 3.
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, "oneshot_start");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "oneshot_run");
        check1("oneshot_exp", {28'd0, exp_cnt}, 32'd1);
        check1("oneshot_busy", {31'd0, busy}, 32'd0);

        // Periodic from 2: pulses every 3 cycles, tally saturates at 15.
        applyStimulus(1'b1, 8'd2, 1'b1, 1'b0, 1'b0, "periodic_start");
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (ready === 1'b1) pulses++;
            applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "periodic_run");
        end
        check1("periodic_pulses_9cyc", pulses, 32'd3);
        for (int i = 0; i < 45; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "periodic_sat");
        check1("periodic_exp_sat", {28'd0, exp_cnt}, 32'd15);

        // Abort together with start at count 2.
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, "abort_start");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "abort_run");
        check1("abort_pre_count", {24'd0, count}, 32'd2);
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b1, 1'b0, "abort_edge");
        check1("abort_count", {24'd0, count}, 32'd0);
        check1("abort_busy", {31'd0, busy}, 32'd0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "abort_after");

        // Zero load, one-shot.
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "zero_start");
        check1("zero_ready", {31'd0, ready}, 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "zero_fire");
        check1("zero_idle", {31'd0, busy}, 32'd0);
        check1("zero_no_ready", {31'd0, ready}, 32'd0);

        // Zero load, periodic: ready every cycle.
        applyStimulus(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, "zero_per_start");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "zero_per_run");
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, "zero_per_abort");

        // Asynchronous reset at count 4.
        applyStimulus(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, "arst_start");
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "arst_run");
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "arst_run");
        check1("arst_pre_count", {24'd0, count}, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check1("arst_count", {24'd0, count}, 32'd0);
        check1("arst_busy", {31'd0, busy}, 32'd0);
        check1("arst_ready", {31'd0, ready}, 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "arst_after");

`ifdef COUNTDOWN_PAUSE_EN
        // Pause three cycles at count 2.
        applyStimulus(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, "pause_start");
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "pause_run");
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "pause_run");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "pause_hold");
            check1("pause_count", {24'd0, count}, 32'd2);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "pause_tail");
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0),
                          8'($urandom_range(0, 6)),
                          1'($urandom),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) == 0),
                          "random");
        end

        $display("[TB] done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
